// File: rtl/sdhci_pkg.sv
// Shared SDHCI types for the command-path blocks: response encodings, the
// response/status FSM state set and the interrupt-status pulse bundle.
package sdhci_pkg;

  typedef enum logic [1:0] {
    RSP_NONE    = 2'b00,
    RSP_136     = 2'b01,
    RSP_48      = 2'b10,
    RSP_48_BUSY = 2'b11
  } response_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_CMD,
    ST_WAIT_RSP,
    ST_BUSY_WAIT
  } cmd_rsp_state_e;

  typedef struct packed {
    logic cmd_complete;
    logic xfer_complete;
    logic cmd_timeout;
    logic cmd_crc;
    logic cmd_end_bit;
    logic cmd_index;
    logic busy_timeout;
    logic auto_cmd12;
  } status_pulses_t;

  // Auto CMD12 responses land in the top word of the Response registers
  localparam int RESP_AUTO_CMD12_LSB = 96;

  function automatic logic is_48bit(input response_type_e t);
    return (t == RSP_48) || (t == RSP_48_BUSY);
  endfunction

endpackage

// File: rtl/busy_timer.sv
// Saturating tick counter with a programmable limit; a zero limit never fires.
// hit_o flags the tick on which the count reaches the limit.
module busy_timer #(
  parameter int CNT_W = 20
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             tick_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             hit_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_inc;

  assign count_inc = (&count_q) ? count_q : count_q + CNT_W'(1);

  // Compares the post-tick value so the limit fires on the Nth tick itself
  assign hit_o = tick_i && (limit_i != '0) && (count_inc >= limit_i);

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      count_q <= '0;
    end else if (tick_i) begin
      count_q <= count_inc;
    end
  end

endmodule

// File: rtl/cmd_rsp_status.sv
// Turns command-engine results into SDHCI Response register contents and
// one-cycle interrupt-status set pulses, including R1b busy tracking on DAT0.
module cmd_rsp_status
  import sdhci_pkg::*;
#(
  parameter int BUSY_CNT_W = 20
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clk_en_p_i,
  input  logic                  issue_i,
  output logic                  issue_ready_o,
  input  response_type_e        response_type_i,
  input  logic                  crc_check_en_i,
  input  logic                  index_check_en_i,
  input  logic                  auto_cmd12_i,
  input  logic                  cmd_done_i,
  input  logic                  rsp_valid_i,
  input  logic [119:0]          rsp_i,
  input  logic                  index_error_i,
  input  logic                  end_bit_error_i,
  input  logic                  crc_error_i,
  input  logic                  timeout_error_i,
  input  logic                  dat0_i,
  input  logic [BUSY_CNT_W-1:0] busy_timeout_i,
  input  logic                  abort_i,
  output logic [127:0]          resp_o,
  output logic                  cmd_complete_o,
  output logic                  xfer_complete_o,
  output logic                  cmd_timeout_err_o,
  output logic                  cmd_crc_err_o,
  output logic                  cmd_end_bit_err_o,
  output logic                  cmd_index_err_o,
  output logic                  busy_timeout_err_o,
  output logic                  auto_cmd12_err_o,
  output logic                  busy_o
);

  cmd_rsp_state_e state_q, state_d;
  response_type_e ctx_type_q;
  logic           ctx_crc_q, ctx_idx_q, ctx_auto_q;
  logic [127:0]   resp_q, resp_d;
  status_pulses_t pulse_q, pulse_d;
  logic           crc_err, idx_err, end_err;
  logic           timer_clear, timer_tick, timer_hit;

  busy_timer #(
    .CNT_W(BUSY_CNT_W)
  ) u_busy_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear_i(timer_clear),
    .tick_i (timer_tick),
    .limit_i(busy_timeout_i),
    .hit_o  (timer_hit)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      resp_q  <= '0;
      pulse_q <= '0;
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
      pulse_q <= pulse_d;
    end
  end

  // Command context is captured once at issue and held until the next issue
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctx_type_q <= RSP_NONE;
      ctx_crc_q  <= 1'b0;
      ctx_idx_q  <= 1'b0;
      ctx_auto_q <= 1'b0;
    end else if (state_q == ST_IDLE && issue_i && !abort_i) begin
      ctx_type_q <= response_type_i;
      ctx_crc_q  <= crc_check_en_i;
      ctx_idx_q  <= index_check_en_i;
      ctx_auto_q <= auto_cmd12_i;
    end
  end

  always_comb begin
    state_d     = state_q;
    resp_d      = resp_q;
    pulse_d     = '0;
    crc_err     = 1'b0;
    idx_err     = 1'b0;
    end_err     = 1'b0;
    timer_clear = 1'b0;
    timer_tick  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (issue_i) state_d = ST_WAIT_CMD;
      end
      ST_WAIT_CMD: begin
        if (cmd_done_i) begin
          if (ctx_type_q == RSP_NONE) begin
            pulse_d.cmd_complete = 1'b1;
            state_d              = ST_IDLE;
          end else begin
            state_d = ST_WAIT_RSP;
          end
        end
      end
      ST_WAIT_RSP: begin
        if (timeout_error_i) begin
          // Timeout plus CRC error is the SDHCI encoding for a CMD-line conflict
          pulse_d.cmd_timeout = 1'b1;
          pulse_d.cmd_crc     = ctx_crc_q;
          state_d             = ST_IDLE;
        end else if (rsp_valid_i) begin
          crc_err              = crc_error_i & ctx_crc_q;
          idx_err              = index_error_i & ctx_idx_q & is_48bit(ctx_type_q);
          end_err              = end_bit_error_i;
          pulse_d.cmd_complete = 1'b1;
          pulse_d.cmd_crc      = crc_err;
          pulse_d.cmd_index    = idx_err;
          pulse_d.cmd_end_bit  = end_err;
          if (ctx_type_q == RSP_136) begin
            resp_d = {8'h00, rsp_i};
          end else if (ctx_auto_q) begin
            resp_d[RESP_AUTO_CMD12_LSB +: 32] = rsp_i[31:0];
          end else begin
            resp_d[31:0] = rsp_i[31:0];
          end
          if (ctx_type_q == RSP_48_BUSY && !(crc_err || idx_err || end_err)) begin
            state_d     = ST_BUSY_WAIT;
            timer_clear = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_BUSY_WAIT: begin
        timer_tick = clk_en_p_i;
        if (clk_en_p_i && dat0_i) begin
          pulse_d.xfer_complete = 1'b1;
          state_d               = ST_IDLE;
        end else if (timer_hit) begin
          pulse_d.busy_timeout = 1'b1;
          state_d              = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    pulse_d.auto_cmd12 = ctx_auto_q & (pulse_d.cmd_timeout | pulse_d.cmd_crc |
                                       pulse_d.cmd_end_bit | pulse_d.cmd_index |
                                       pulse_d.busy_timeout);

    if (abort_i) begin
      state_d     = ST_IDLE;
      resp_d      = resp_q;
      pulse_d     = '0;
      timer_clear = 1'b1;
      timer_tick  = 1'b0;
    end
  end

  assign issue_ready_o      = (state_q == ST_IDLE);
  assign busy_o             = (state_q == ST_BUSY_WAIT);
  assign resp_o             = resp_q;
  assign cmd_complete_o     = pulse_q.cmd_complete;
  assign xfer_complete_o    = pulse_q.xfer_complete;
  assign cmd_timeout_err_o  = pulse_q.cmd_timeout;
  assign cmd_crc_err_o      = pulse_q.cmd_crc;
  assign cmd_end_bit_err_o  = pulse_q.cmd_end_bit;
  assign cmd_index_err_o    = pulse_q.cmd_index;
  assign busy_timeout_err_o = pulse_q.busy_timeout;
  assign auto_cmd12_err_o   = pulse_q.auto_cmd12;

endmodule
